// File: rtl/euler_pkg.sv
// Shared constants for the Euler job scheduler: FSM encoding and default sizing.
package euler_pkg;

  localparam int SUM_W_DEF   = 32;
  localparam int LIM_W_DEF   = 16;
  localparam int DIV_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 70000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mult_sum_core.sv
// Sums every n in [0,limit) divisible by div_a or div_b, one n per cycle,
// tracking divisibility with wrap-around residue counters instead of a divider.
module mult_sum_core
  import euler_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int LIM_W = LIM_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LIM_W-1:0] limit,
  input  logic [DIV_W-1:0] div_a,
  input  logic [DIV_W-1:0] div_b,
  output logic             done,
  output logic [SUM_W-1:0] sum
);

  logic             active_reg;
  logic [LIM_W-1:0] n_reg;
  logic [DIV_W-1:0] ra_reg;
  logic [DIV_W-1:0] rb_reg;
  logic [SUM_W-1:0] acc_reg;
  logic             hit;
  logic [SUM_W-1:0] contrib;

  // A common multiple hits both residues at once but is still added only once.
  assign hit     = active_reg && ((ra_reg == '0) || (rb_reg == '0));
  assign contrib = hit ? SUM_W'(n_reg) : '0;

  // sum includes the n examined this cycle, so a caller stopping early can latch it.
  assign sum  = acc_reg + contrib;
  assign done = active_reg && (n_reg == limit - LIM_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_reg <= 1'b0;
      n_reg      <= '0;
      ra_reg     <= '0;
      rb_reg     <= '0;
      acc_reg    <= '0;
    end else if (start) begin
      active_reg <= 1'b1;
      n_reg      <= '0;
      ra_reg     <= '0;
      rb_reg     <= '0;
      acc_reg    <= '0;
    end else if (active_reg) begin
      acc_reg <= sum;
      n_reg   <= n_reg + LIM_W'(1);
      ra_reg  <= (ra_reg == div_a - DIV_W'(1)) ? '0 : ra_reg + DIV_W'(1);
      rb_reg  <= (rb_reg == div_b - DIV_W'(1)) ? '0 : rb_reg + DIV_W'(1);
      if (done) begin
        active_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/euler_job_sched.sv
// Job scheduler around mult_sum_core: accept handshake, divisor/limit screening,
// RUN cycle counting with timeout, abort, and a held result until taken.
module euler_job_sched
  import euler_pkg::*;
#(
  parameter int SUM_W   = SUM_W_DEF,
  parameter int LIM_W   = LIM_W_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LIM_W-1:0] job_limit,
  input  logic [DIV_W-1:0] job_div_a,
  input  logic [DIV_W-1:0] job_div_b,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_sum,
  output logic [31:0]      res_cycles,
  output logic             res_err,
  output logic             busy
);

  logic [1:0]       state_reg;
  logic [LIM_W-1:0] lim_reg;
  logic [DIV_W-1:0] a_reg;
  logic [DIV_W-1:0] b_reg;
  logic [31:0]      cyc_reg;
  logic [SUM_W-1:0] res_sum_reg;
  logic [31:0]      res_cycles_reg;
  logic             res_err_reg;
  logic             div_zero;
  logic             core_start;
  logic             core_done;
  logic [SUM_W-1:0] core_sum;

  assign div_zero   = (a_reg == '0) || (b_reg == '0);
  assign core_start = (state_reg == ST_CHECK) && !abort && !div_zero && (lim_reg != '0);

  assign job_ready  = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign res_valid  = (state_reg == ST_DONE);
  assign res_sum    = res_sum_reg;
  assign res_cycles = res_cycles_reg;
  assign res_err    = res_err_reg;

  mult_sum_core #(
    .SUM_W(SUM_W),
    .LIM_W(LIM_W),
    .DIV_W(DIV_W)
  ) u_core (
    .clk  (clk),
    .reset(reset),
    .start(core_start),
    .limit(lim_reg),
    .div_a(a_reg),
    .div_b(b_reg),
    .done (core_done),
    .sum  (core_sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      lim_reg        <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      cyc_reg        <= '0;
      res_sum_reg    <= '0;
      res_cycles_reg <= '0;
      res_err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (job_valid) begin
            lim_reg   <= job_limit;
            a_reg     <= job_div_a;
            b_reg     <= job_div_b;
            cyc_reg   <= '0;
            state_reg <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (abort) begin
            state_reg <= ST_IDLE;
          end else if (div_zero || (lim_reg == '0)) begin
            res_sum_reg    <= '0;
            res_cycles_reg <= '0;
            res_err_reg    <= div_zero;
            state_reg      <= ST_DONE;
          end else begin
            cyc_reg   <= '0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Abort beats completion, and completion beats a coincident timeout.
          if (abort) begin
            state_reg <= ST_IDLE;
          end else if (core_done) begin
            res_sum_reg    <= core_sum;
            res_cycles_reg <= cyc_reg + 32'd1;
            res_err_reg    <= 1'b0;
            state_reg      <= ST_DONE;
          end else if (cyc_reg + 32'd1 == 32'(TIMEOUT)) begin
            res_sum_reg    <= core_sum;
            res_cycles_reg <= 32'(TIMEOUT);
            res_err_reg    <= 1'b1;
            state_reg      <= ST_DONE;
          end else begin
            cyc_reg <= cyc_reg + 32'd1;
          end
        end
        default: begin
          if (res_ready) begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_euler_job_sched.sv
// Bench for euler_job_sched: vector table plus hand sequences for hold-off,
// stability, abort, timeout and mid-job reset, with a result scoreboard.
module tb_euler_job_sched;

  logic        clk;
  logic        reset;
  logic        job_valid, job_ready, abort, res_valid, res_ready, res_err, busy;
  logic [15:0] job_limit;
  logic [7:0]  job_div_a, job_div_b;
  logic [31:0] res_sum, res_cycles;

  logic        t_job_valid, t_job_ready, t_abort, t_res_valid, t_res_ready, t_res_err, t_busy;
  logic [15:0] t_job_limit;
  logic [7:0]  t_job_div_a, t_job_div_b;
  logic [31:0] t_res_sum, t_res_cycles;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] cycles;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] limit;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] sum;
    logic [31:0] cycles;
    logic        err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;
  int   ready_bad;

  euler_job_sched dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_limit(job_limit), .job_div_a(job_div_a), .job_div_b(job_div_b),
    .abort(abort), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cycles(res_cycles), .res_err(res_err), .busy(busy)
  );

  euler_job_sched #(.TIMEOUT(50)) dut_to (
    .clk(clk), .reset(reset), .job_valid(t_job_valid), .job_ready(t_job_ready),
    .job_limit(t_job_limit), .job_div_a(t_job_div_a), .job_div_b(t_job_div_b),
    .abort(t_abort), .res_valid(t_res_valid), .res_ready(t_res_ready),
    .res_sum(t_res_sum), .res_cycles(t_res_cycles), .res_err(t_res_err), .busy(t_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  // Called at the accept edge; waits for res_valid and checks against the scoreboard.
  task automatic wait_main(input string tag, input bit drop_valid);
    exp_t e;
    int   edges;
    edges = 1;
    @(negedge clk);
    if (drop_valid) job_valid = 1'b0;
    while (!res_valid && edges < 2000) begin
      if (job_ready) ready_bad++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check({tag, "_latency"}, edges, e.lat);
    check({tag, "_sum"}, res_sum, e.sum);
    check({tag, "_cycles"}, res_cycles, e.cycles);
    check({tag, "_err"}, res_err, e.err);
  endtask

  task automatic push_exp(input logic [15:0] lim, input logic [31:0] s,
                          input logic [31:0] c, input logic err);
    exp_t e;
    e.sum = s; e.cycles = c; e.err = err;
    e.lat = (err || lim == 16'd0) ? 2 : int'(lim) + 2;
    sb.push_back(e);
  endtask

  task automatic drive_job(input logic [15:0] lim, input logic [7:0] a, input logic [7:0] b);
    job_valid = 1'b1; job_limit = lim; job_div_a = a; job_div_b = b;
  endtask

  initial begin
    int edges;
    int stable_bad;
    exp_t e;

    vecs[0] = '{16'd1000, 8'd3,   8'd5,  32'd233168, 32'd1000, 1'b0};
    vecs[1] = '{16'd10,   8'd3,   8'd5,  32'd23,     32'd10,   1'b0};
    vecs[2] = '{16'd0,    8'd3,   8'd5,  32'd0,      32'd0,    1'b0};
    vecs[3] = '{16'd10,   8'd0,   8'd5,  32'd0,      32'd0,    1'b1};
    vecs[4] = '{16'd7,    8'd2,   8'd0,  32'd0,      32'd0,    1'b1};
    vecs[5] = '{16'd1,    8'd4,   8'd6,  32'd0,      32'd1,    1'b0};
    vecs[6] = '{16'd20,   8'd4,   8'd6,  32'd64,     32'd20,   1'b0};
    vecs[7] = '{16'd16,   8'd1,   8'd7,  32'd120,    32'd16,   1'b0};
    vecs[8] = '{16'd13,   8'd13,  8'd13, 32'd0,      32'd13,   1'b0};
    vecs[9] = '{16'd12,   8'd255, 8'd2,  32'd30,     32'd12,   1'b0};

    reset = 1'b0; job_valid = 1'b0; job_limit = '0; job_div_a = '0; job_div_b = '0;
    abort = 1'b0; res_ready = 1'b0;
    t_job_valid = 1'b0; t_job_limit = '0; t_job_div_a = '0; t_job_div_b = '0;
    t_abort = 1'b0; t_res_ready = 1'b0;
    ready_bad = 0;
    #12;
    check("rst_job_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_fields", {res_sum, res_cycles, res_err}, 0);
    check("rst_to_busy", t_busy, 0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven jobs with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_job_ready", i), job_ready, 1);
      push_exp(vecs[i].limit, vecs[i].sum, vecs[i].cycles, vecs[i].err);
      drive_job(vecs[i].limit, vecs[i].a, vecs[i].b);
      res_ready = 1'b1;
      @(posedge clk);
      wait_main($sformatf("v%0d", i), 1'b1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_idle_after_take", i), busy, 0);
    end

    // job_valid held through a 100-cycle job; result held with res_ready low.
    @(negedge clk);
    res_ready = 1'b0;
    ready_bad = 0;
    push_exp(16'd100, 32'd2318, 32'd100, 1'b0);
    drive_job(16'd100, 8'd3, 8'd5);
    @(posedge clk);
    wait_main("hold", 1'b0);
    check("hold_no_second_accept", ready_bad, 0);
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      abort = (i == 3);
      @(posedge clk);
      @(negedge clk);
      if (res_valid !== 1'b1 || res_sum !== 32'd2318 || res_cycles !== 32'd100 ||
          res_err !== 1'b0 || job_ready !== 1'b0) stable_bad++;
    end
    abort = 1'b0;
    check("hold_stable_10cyc", stable_bad, 0);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold_ready_after_take", job_ready, 1);
    res_ready = 1'b0;

    // job_valid still high: second job accepted now, then aborted at RUN cycle 20.
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    check("second_accept_busy", busy, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1) stable_bad++;
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_idle_no_result", stable_bad, 0);

    // Timeout instance: TIMEOUT=50, N=100, a=b=1.
    t_job_valid = 1'b1; t_job_limit = 16'd100; t_job_div_a = 8'd1; t_job_div_b = 8'd1;
    t_res_ready = 1'b1;
    e.sum = 32'd1225; e.cycles = 32'd50; e.err = 1'b1; e.lat = 52;
    sb.push_back(e);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    t_job_valid = 1'b0;
    while (!t_res_valid && edges < 500) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check("to_latency", edges, e.lat);
    check("to_sum", t_res_sum, e.sum);
    check("to_cycles", t_res_cycles, e.cycles);
    check("to_err", t_res_err, e.err);
    @(posedge clk);
    @(negedge clk);
    check("to_idle_after_take", t_busy, 0);

    // Reset asserted at RUN cycle 5, then accept on the first edge after release.
    drive_job(16'd100, 8'd3, 8'd5);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_job_ready", job_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_fields", {res_sum, res_cycles, res_err}, 0);
    push_exp(16'd10, 32'd23, 32'd10, 1'b0);
    drive_job(16'd10, 8'd3, 8'd5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    wait_main("post_rst", 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("post_rst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/euler_job_sched.md
EULER_JOB_SCHED -- requirements
Module: euler_job_sched

Interface
REQ-001 Parameters SHALL be: SUM_W, default 32, result/sum width; LIM_W, default 16, job limit width; DIV_W, default 8, divisor width; TIMEOUT, default 70000, maximum RUN cycles before an error result.
REQ-002 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset (0 = in reset).
REQ-004 Port job_valid, input, 1: a job is offered.
REQ-005 Port job_ready, output, 1: the scheduler accepts a job.
REQ-006 Port job_limit, input, LIM_W: exclusive upper bound N.
REQ-007 Port job_div_a and port job_div_b, input, DIV_W each: the two divisors.
REQ-008 Port abort, input, 1: synchronous cancel of a running job.
REQ-009 Port res_valid, output, 1: a result is presented.
REQ-010 Port res_ready, input, 1: the consumer takes the result.
REQ-011 Port res_sum, output, SUM_W: the sum of n in [0,N) with n divisible by div_a or div_b.
REQ-012 Port res_cycles, output, 32: the number of RUN cycles consumed.
REQ-013 Port res_err, output, 1: the job failed (zero divisor or timeout).
REQ-014 Port busy, output, 1: high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, CHECK, RUN and DONE; job_ready SHALL be 1 only in IDLE.
REQ-016 Accept: when job_valid and job_ready are both high at a clock edge, the scheduler SHALL latch limit and divisors and go to CHECK; it SHALL ignore job_valid in every other state.
REQ-017 CHECK: if either divisor is 0, the scheduler SHALL go to DONE with res_err=1, res_sum=0 and res_cycles=0; if limit is 0, it SHALL go to DONE with res_err=0, res_sum=0 and res_cycles=0; otherwise it SHALL pulse core start and go to RUN.
REQ-018 RUN: the core SHALL examine one n per cycle from n=0 to N-1 in order, using wrap-around residue counters (no divider); RUN SHALL last exactly N cycles, so res_cycles=N.
REQ-019 In RUN, an n that is a multiple of both divisors SHALL be added once only.
REQ-020 Accept-to-res_valid latency SHALL be N+2 cycles for N>0, and 2 cycles for the CHECK-terminated cases.
REQ-021 Width rule: the accumulator is SUM_W bits and wraps modulo 2^SUM_W; with the defaults no overflow is reachable.
REQ-022 Timeout: if the RUN cycle count reaches TIMEOUT before the core signals done, the scheduler SHALL go to DONE with res_err=1, res_sum equal to the partial sum, and res_cycles=TIMEOUT.
REQ-023 Abort: abort high in RUN or CHECK SHALL return the FSM to IDLE on the next edge with no result; abort in IDLE or DONE SHALL have no effect.
REQ-024 If abort and the timeout or completion condition occur in the same cycle, abort SHALL take priority.
REQ-025 DONE: res_valid=1 with res_sum, res_cycles and res_err held stable until res_ready is high at an edge, then the FSM SHALL go to IDLE; a new job SHALL be accepted no earlier than the cycle after the result is taken.

Reset
REQ-026 On reset=0, asynchronously: state=IDLE, job_ready=1, busy=0, res_valid=0, res_sum=0, res_cycles=0, res_err=0, and all latches and counters cleared.
REQ-027 Reset asserted mid-job SHALL discard the job with no result; the first accept SHALL be possible on the first edge after reset deassertion.

Structure
REQ-028 The FSM state encoding and the default parameter constants SHALL live in the shared package euler_pkg.
REQ-029 The datapath SHALL be the sub-module mult_sum_core, which holds the residue counters and the accumulator and has the ports clk, reset, start, limit, div_a, div_b, done and sum; euler_job_sched holds the FSM, the handshakes and the cycle/timeout counting.

Verification
REQ-030 Job N=1000, a=3, b=5, res_ready=1 -> res_sum=233168, res_cycles=1000, res_err=0, res_valid on accept+1002.
REQ-031 Job N=10, a=3, b=5 -> res_sum=23 (multiples 0, 3, 5, 6, 9); job N=0 -> res_sum=0 after 2 cycles.
REQ-032 Job with a=0 -> res_err=1, res_sum=0, res_cycles=0; job_valid held during RUN of a 100-cycle job -> no second accept until the first result is taken.
REQ-033 TIMEOUT=50, job N=100, a=b=1 -> res_err=1, res_cycles=50, res_sum=1225.
REQ-034 Abort asserted at RUN cycle 20 -> IDLE, no res_valid; reset=0 at RUN cycle 5 -> all outputs at reset values immediately; res_ready held low for 10 cycles -> outputs stable throughout.
